// File: rtl/muldiv_if.sv
// Request/response bundle between the control FSM and the iterative RV32M mul/div unit.
// The master issues start/op/operands, and the slave returns the result with busy/done.
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [2:0]            op_i;
  logic [DATA_WIDTH-1:0] srcA_i;
  logic [DATA_WIDTH-1:0] srcB_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (output start_i, op_i, srcA_i, srcB_i, input result_o, busy_o, done_o);
  modport slave  (input start_i, op_i, srcA_i, srcB_i, output result_o, busy_o, done_o);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add / restoring divide on magnitudes,
// followed by one sign-fixup cycle. One operation is in flight at a time (start/busy/done).
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  muldiv_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic            sign_a, sign_b;
  logic [W-1:0]    mag_b;
  logic [2*W-1:0]  acc;      // mul: {hi, multiplier/lo}; div: {remainder, dividend/quotient}
  logic [CW-1:0]   count;
  logic [W-1:0]    result;

  // Issue-side decode
  logic            sa_in, sb_in, is_div, div_zero, div_ovf, special;
  logic [W-1:0]    abs_a, abs_b, special_res;

  always_comb begin
    is_div   = bus.op_i[2];
    sa_in    = bus.srcA_i[W-1] & (bus.op_i == OP_MULH || bus.op_i == OP_MULHSU ||
                                  bus.op_i == OP_DIV  || bus.op_i == OP_REM);
    sb_in    = bus.srcB_i[W-1] & (bus.op_i == OP_MULH || bus.op_i == OP_DIV ||
                                  bus.op_i == OP_REM);
    abs_a    = sa_in ? (~bus.srcA_i + 1'b1) : bus.srcA_i;
    abs_b    = sb_in ? (~bus.srcB_i + 1'b1) : bus.srcB_i;
    div_zero = is_div && (bus.srcB_i == '0);
    div_ovf  = is_div && !bus.op_i[0] && (bus.srcA_i == {1'b1, {(W-1){1'b0}}}) &&
               (bus.srcB_i == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.op_i[1] ? bus.srcA_i : '1;
    else          special_res = bus.op_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
  end

  // One iteration step and the final sign fixup
  logic [W:0]      mul_sum, rem_sh, diff;
  logic [2*W-1:0]  acc_step, prod;
  logic [W-1:0]    quo, rem, fix_res;

  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : '0);
    rem_sh  = {acc[2*W-1:W], acc[W-1]};
    diff    = rem_sh - {1'b0, mag_b};
    if (op_q[2]) begin
      // Borrow clear means the trial subtraction fits: keep it and set the quotient bit
      if (!diff[W]) acc_step = {diff[W-1:0],   acc[W-2:0], 1'b1};
      else          acc_step = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[W-1:1]};
    end
    prod    = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo     = (sign_a ^ sign_b) ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
    rem     = sign_a ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
    if (op_q[2])              fix_res = op_q[1] ? rem : quo;
    else if (op_q == OP_MUL)  fix_res = prod[W-1:0];
    else                      fix_res = prod[2*W-1:W];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = special ? DONE : CALC;
      CALC:    if (count == CW'(W-1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_b  <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          op_q   <= bus.op_i;
          sign_a <= sa_in;
          sign_b <= sb_in;
          mag_b  <= abs_b;
          acc    <= {{W{1'b0}}, abs_a};
          count  <= '0;
          if (special) result <= special_res;
        end
        CALC: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        FIXUP:   result <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.busy_o   = (state != IDLE);
  assign bus.done_o   = (state == DONE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, sign handling, special cases,
// start-while-busy, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_if #(.DATA_WIDTH(32)) bus ();
  muldiv_unit #(.DATA_WIDTH(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Issue one op starting at a negedge; returns at the negedge of the cycle after done.
  // lat counts cycles after the start cycle until done_o is seen (-1 on timeout).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cyc,
                        output logic done_after);
    bus.start_i = 1'b1; bus.op_i = op; bus.srcA_i = a; bus.srcB_i = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.srcA_i = 32'h0BAD_F00D; bus.srcB_i = 32'h1234_5678;
    lat = -1; busy_cyc = 0; res = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cyc++;
      if (bus.done_o) begin lat = c; res = bus.result_o; break; end
    end
    @(negedge clk);
    done_after = bus.done_o;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL reset_result got=%h exp=%h", bus.result_o, 32'h0); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul_basic();
    logic [31:0] r; int lat, bc; logic d2;
    run_op(3'b000, 32'd7, 32'd6, r, lat, bc, d2);
    n_cmp++; if (r !== 32'h0000_002A) begin n_bad++; $display("FAIL mul_7x6 got=%h exp=%h", r, 32'h2A); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL mul_latency got=%0d exp=34", lat); end
    n_cmp++; if (bc !== 34) begin n_bad++; $display("FAIL mul_busy_cycles got=%0d exp=34", bc); end
    n_cmp++; if (d2 !== 1'b0) begin n_bad++; $display("FAIL mul_done_width got=%b exp=0", d2); end
  endtask

  task automatic test_mul_signs();
    logic [2:0]  ops [4] = '{3'b001, 3'b010, 3'b011, 3'b000};
    logic [31:0] exp [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    logic [31:0] r; int lat, bc; logic d2;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, d2);
      n_cmp++; if (r !== exp[i]) begin n_bad++; $display("FAIL mul_ffff op=%b got=%h exp=%h", ops[i], r, exp[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_000E, 32'h0000_0002};
    logic [31:0] r; int lat, bc; logic d2;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bc, d2);
      n_cmp++; if (r !== exp[i]) begin n_bad++; $display("FAIL div op=%b got=%h exp=%h", ops[i], r, exp[i]); end
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL div_latency op=%b got=%0d exp=34", ops[i], lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] r; int lat, bc; logic d2;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bc, d2);
      n_cmp++; if (r !== exp[i]) begin n_bad++; $display("FAIL special%0d got=%h exp=%h", i, r, exp[i]); end
      n_cmp++; if (lat !== 1 || bc !== 1) begin n_bad++; $display("FAIL special%0d_timing lat=%0d busy=%0d exp=1/1", i, lat, bc); end
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0; int done_at = -1; logic [31:0] r = 'x;
    bus.start_i = 1'b1; bus.op_i = 3'b000; bus.srcA_i = 32'd7; bus.srcB_i = 32'd6;
    @(posedge clk); #1;
    bus.op_i = 3'b101; bus.srcA_i = 32'd1000; bus.srcB_i = 32'd3;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.done_o) begin dones++; if (done_at < 0) begin done_at = c; r = bus.result_o; end end
      if (c == 30) bus.start_i = 1'b0;
    end
    n_cmp++; if (r !== 32'h0000_002A) begin n_bad++; $display("FAIL ignore_result got=%h exp=%h", r, 32'h2A); end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    n_cmp++; if (done_at !== 34) begin n_bad++; $display("FAIL ignore_latency got=%0d exp=34", done_at); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat, bc; logic d2;
    run_op(3'b101, 32'd9, 32'd0, r, lat, bc, d2);
    run_op(3'b110, 32'd9, 32'd0, r, lat, bc, d2);
    n_cmp++; if (r !== 32'd9 || lat !== 1) begin n_bad++; $display("FAIL b2b_special got=%h/%0d exp=%h/1", r, lat, 32'd9); end
    run_op(3'b000, 32'd3, 32'd5, r, lat, bc, d2);
    n_cmp++; if (r !== 32'd15) begin n_bad++; $display("FAIL b2b_mul got=%h exp=%h", r, 32'd15); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
    run_op(3'b111, 32'd23, 32'd5, r, lat, bc, d2);
    n_cmp++; if (r !== 32'd3 || lat !== 34) begin n_bad++; $display("FAIL b2b_remu got=%h/%0d exp=%h/34", r, lat, 32'd3); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat, bc; logic d2;
    bus.start_i = 1'b1; bus.op_i = 3'b000; bus.srcA_i = 32'd11; bus.srcB_i = 32'd13;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL midrst_result got=%h exp=0", bus.result_o); end
    n_cmp++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin n_bad++; $display("FAIL midrst_flags busy=%b done=%b exp=0/0", bus.busy_o, bus.done_o); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b011, 32'h8000_0000, 32'd4, r, lat, bc, d2);
    n_cmp++; if (r !== 32'h0000_0002) begin n_bad++; $display("FAIL midrst_mulhu got=%h exp=%h", r, 32'h2); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL midrst_latency got=%0d exp=34", lat); end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.op_i = '0; bus.srcA_i = '0; bus.srcB_i = '0;
    test_reset();
    test_mul_basic();
    test_mul_signs();
    test_div();
    test_special();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
